// File: rtl/ac97_pkg.sv
// Shared constants, tag bit positions and FSM state type for the AC97 input-frame receiver.
package ac97_pkg;

  localparam int TAG_W      = 16;
  localparam int SLOT_W     = 20;
  localparam int FRAME_BITS = 256;
  localparam int NSLOTS     = 12;

  localparam int TAG_READY = 15;
  localparam int TAG_S1    = 14;
  localparam int TAG_S2    = 13;
  localparam int TAG_S3    = 12;
  localparam int TAG_S4    = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TAG,
    ST_SLOTS
  } rx_state_e;

  // Status read-back is only meaningful when the codec flags both slot 1 and slot 2.
  function automatic logic status_ok(input logic [TAG_W-1:0] t);
    return t[TAG_S1] & t[TAG_S2];
  endfunction

endpackage

// File: rtl/ac97_rx_if.sv
// Bundle of the codec-facing serial inputs and the decoded frame outputs of ac97_rx.
interface ac97_rx_if
  import ac97_pkg::*;
#(
  parameter int PCM_W = 16
);

  logic              AUDIO_SYNC;
  logic              AUDIO_SDATA_IN;
  logic [TAG_W-1:0]  tag;
  logic              codec_ready;
  logic [6:0]        status_addr;
  logic [15:0]       status_data;
  logic [PCM_W-1:0]  pcm_l;
  logic [PCM_W-1:0]  pcm_r;
  logic              frame_valid;
  logic              status_valid;
  logic              sync_err;

  modport master (
    output AUDIO_SYNC, AUDIO_SDATA_IN,
    input  tag, codec_ready, status_addr, status_data,
    input  pcm_l, pcm_r, frame_valid, status_valid, sync_err
  );

  modport slave (
    input  AUDIO_SYNC, AUDIO_SDATA_IN,
    output tag, codec_ready, status_addr, status_data,
    output pcm_l, pcm_r, frame_valid, status_valid, sync_err
  );

endinterface

// File: rtl/ac97_slot_shift.sv
// MSB-first slot deserialiser; done pulses the cycle after the last bit of a word was shifted in.
module ac97_slot_shift
  import ac97_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              word_end,
  output logic [SLOT_W-1:0] data,
  output logic              done
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      done <= 1'b0;
    end else begin
      done <= shift_en & word_end;
      if (shift_en) begin
        data <= {data[SLOT_W-2:0], bit_in};
      end
    end
  end

endmodule

// File: rtl/ac97_rx.sv
// AC97 input-frame receiver: deserialises SDATA_IN framed by SYNC and commits tag, status and PCM words.
module ac97_rx
  import ac97_pkg::*;
#(
  parameter int PCM_W = 16
) (
  input logic      AUDIO_BIT_CLK,
  input logic      RESET,
  ac97_rx_if.slave bus
);

  localparam logic [7:0] TAG_LAST   = 8'(TAG_W - 1);
  localparam logic [7:0] SLOT_FIRST = 8'(TAG_W);
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_BITS - 1);
  localparam logic [4:0] SLOT_LAST  = 5'(SLOT_W - 1);

  logic              sync_q;
  logic              sync_prev;
  logic              sdin_q;
  logic              rise;

  rx_state_e         state;
  rx_state_e         state_n;
  logic [7:0]        bitcnt;
  logic [7:0]        bitcnt_n;
  logic [7:0]        frame_bit;

  logic              shift_en;
  logic              word_end;
  logic              commit;
  logic              commit_q;
  logic              frame_err;

  logic [4:0]        slot_bit;
  logic [3:0]        slot_idx;
  logic [3:0]        done_slot;
  logic [SLOT_W-1:0] shift_data;
  logic              shift_done;

  logic [TAG_W-1:0]  tag_h;
  logic [6:0]        addr_h;
  logic [15:0]       sdata_h;
  logic [PCM_W-1:0]  left_h;
  logic [PCM_W-1:0]  right_h;

  always_ff @(posedge AUDIO_BIT_CLK) begin
    if (RESET) begin
      sync_q    <= 1'b0;
      sync_prev <= 1'b0;
      sdin_q    <= 1'b0;
    end else begin
      sync_q    <= bus.AUDIO_SYNC;
      sync_prev <= sync_q;
      sdin_q    <= bus.AUDIO_SDATA_IN;
    end
  end

  assign rise = sync_q & ~sync_prev;

  always_ff @(posedge AUDIO_BIT_CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
    end
  end

  // A rise is itself bit 0, so the counter leaves that cycle already pointing at bit 1.
  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_n  = ST_TAG;
          bitcnt_n = 8'd1;
        end
      end
      ST_TAG: begin
        if (!sync_q) begin
          state_n  = ST_IDLE;
          bitcnt_n = '0;
        end else begin
          bitcnt_n = bitcnt + 8'd1;
          if (bitcnt == TAG_LAST) state_n = ST_SLOTS;
        end
      end
      ST_SLOTS: begin
        if (rise) begin
          state_n  = ST_TAG;
          bitcnt_n = 8'd1;
        end else if ((bitcnt == SLOT_FIRST) && sync_q) begin
          state_n  = ST_IDLE;
          bitcnt_n = '0;
        end else begin
          bitcnt_n = bitcnt + 8'd1;
          if (bitcnt == FRAME_LAST) state_n = ST_IDLE;
        end
      end
      default: begin
        state_n  = ST_IDLE;
        bitcnt_n = '0;
      end
    endcase
  end

  always_comb begin
    frame_bit = bitcnt;
    shift_en  = 1'b0;
    commit    = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          frame_bit = '0;
          shift_en  = 1'b1;
        end
      end
      ST_TAG: begin
        shift_en  = 1'b1;
        frame_err = ~sync_q;
      end
      ST_SLOTS: begin
        shift_en = 1'b1;
        if (rise) begin
          frame_bit = '0;
          frame_err = 1'b1;
        end else if ((bitcnt == SLOT_FIRST) && sync_q) begin
          frame_err = 1'b1;
        end else if (bitcnt == FRAME_LAST) begin
          commit = 1'b1;
        end
      end
      default: begin
        shift_en = 1'b0;
      end
    endcase
    word_end = shift_en &&
               ((frame_bit == TAG_LAST) ||
                ((frame_bit >= SLOT_FIRST) && (slot_bit == SLOT_LAST)));
  end

  // Slot position tracking; done_slot remembers which word the shifter is about to hand over.
  always_ff @(posedge AUDIO_BIT_CLK) begin
    if (RESET) begin
      slot_bit  <= '0;
      slot_idx  <= '0;
      done_slot <= '0;
    end else if (shift_en) begin
      if (frame_bit == TAG_LAST) begin
        slot_bit <= '0;
        slot_idx <= 4'd1;
      end else if (frame_bit >= SLOT_FIRST) begin
        if (slot_bit == SLOT_LAST) begin
          slot_bit <= '0;
          if (slot_idx != 4'(NSLOTS)) slot_idx <= slot_idx + 4'd1;
        end else begin
          slot_bit <= slot_bit + 5'd1;
        end
      end
      if (word_end) done_slot <= (frame_bit == TAG_LAST) ? 4'd0 : slot_idx;
    end
  end

  ac97_slot_shift u_shift (
    .clk      (AUDIO_BIT_CLK),
    .rst      (RESET),
    .shift_en (shift_en),
    .bit_in   (sdin_q),
    .word_end (word_end),
    .data     (shift_data),
    .done     (shift_done)
  );

  always_ff @(posedge AUDIO_BIT_CLK) begin
    if (RESET) begin
      tag_h   <= '0;
      addr_h  <= '0;
      sdata_h <= '0;
      left_h  <= '0;
      right_h <= '0;
    end else if (shift_done) begin
      case (done_slot)
        4'd0:    tag_h   <= shift_data[TAG_W-1:0];
        4'd1:    addr_h  <= shift_data[18:12];
        4'd2:    sdata_h <= shift_data[19:4];
        4'd3:    left_h  <= shift_data[SLOT_W-1 -: PCM_W];
        4'd4:    right_h <= shift_data[SLOT_W-1 -: PCM_W];
        default: ;
      endcase
    end
  end

  // Holding registers only reach the outputs on a clean frame end, so aborted frames leave them untouched.
  always_ff @(posedge AUDIO_BIT_CLK) begin
    if (RESET) begin
      commit_q         <= 1'b0;
      bus.frame_valid  <= 1'b0;
      bus.status_valid <= 1'b0;
      bus.sync_err     <= 1'b0;
      bus.tag          <= '0;
      bus.codec_ready  <= 1'b0;
      bus.status_addr  <= '0;
      bus.status_data  <= '0;
      bus.pcm_l        <= '0;
      bus.pcm_r        <= '0;
    end else begin
      commit_q         <= commit;
      bus.frame_valid  <= commit_q;
      bus.status_valid <= commit_q & status_ok(tag_h);
      bus.sync_err     <= frame_err;
      if (commit_q) begin
        bus.tag         <= tag_h;
        bus.codec_ready <= tag_h[TAG_READY];
        bus.pcm_l       <= left_h;
        bus.pcm_r       <= right_h;
        if (status_ok(tag_h)) begin
          bus.status_addr <= addr_h;
          bus.status_data <= sdata_h;
        end
      end
    end
  end

endmodule

// File: tb/tb_ac97_rx.sv
// Self-checking bench for ac97_rx: directed frames plus random payloads against a frame-level model.
module tb_ac97_rx;

  localparam int PCM_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ac97_rx_if #(.PCM_W(PCM_W)) bus ();

  ac97_rx #(.PCM_W(PCM_W)) dut (
    .AUDIO_BIT_CLK (clock),
    .RESET         (reset),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int fv_cnt  = 0;
  int sv_cnt  = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int fv_cyc[$];

  logic [15:0] tag_v;
  logic [19:0] slot_v [1:12];

  logic [15:0] exp_tag;
  logic        exp_ready;
  logic [6:0]  exp_addr;
  logic [15:0] exp_data;
  logic [15:0] exp_pcm_l;
  logic [15:0] exp_pcm_r;
  int          exp_fv;
  int          exp_sv;
  int          exp_err;

  // Strobe counters sampled just after each rising edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (bus.frame_valid === 1'b1) begin
      fv_cnt++;
      fv_cyc.push_back(cyc);
    end
    if (bus.status_valid === 1'b1) sv_cnt++;
    if (bus.sync_err === 1'b1) err_cnt++;
  end

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic driveBit(input logic s, input logic d);
    @(negedge clock);
    bus.AUDIO_SYNC     = s;
    bus.AUDIO_SDATA_IN = d;
  endtask

  task automatic driveIdle(input int n);
    for (int i = 0; i < n; i++) driveBit(1'b0, 1'($urandom));
  endtask

  task automatic applyStimulus(input logic [255:0] frame, input int sync_len, input int nbits);
    for (int i = 0; i < nbits; i++) driveBit(i < sync_len, frame[255-i]);
  endtask

  function automatic logic [255:0] buildFrame();
    logic [255:0] f;
    f = '0;
    f[255 -: 16] = tag_v;
    for (int n = 1; n <= 12; n++) f[239 - 20*(n-1) -: 20] = slot_v[n];
    return f;
  endfunction

  task automatic newFrame(input logic [15:0] t);
    tag_v = t;
    for (int n = 1; n <= 12; n++) slot_v[n] = 20'($urandom);
  endtask

  task automatic modelReset();
    exp_tag   = '0;
    exp_ready = 1'b0;
    exp_addr  = '0;
    exp_data  = '0;
    exp_pcm_l = '0;
    exp_pcm_r = '0;
  endtask

  task automatic modelCommit();
    exp_tag   = tag_v;
    exp_ready = tag_v[15];
    exp_pcm_l = 16'(slot_v[3] >> (20 - PCM_W));
    exp_pcm_r = 16'(slot_v[4] >> (20 - PCM_W));
    exp_fv++;
    if ((tag_v & 16'h6000) == 16'h6000) begin
      exp_addr = 7'((slot_v[1] >> 12) & 20'h7F);
      exp_data = 16'(slot_v[2] >> 4);
      exp_sv++;
    end
  endtask

  task automatic checkAll(input string name);
    checkOutput({name, "_tag"},   32'(bus.tag),         32'(exp_tag));
    checkOutput({name, "_ready"}, 32'(bus.codec_ready), 32'(exp_ready));
    checkOutput({name, "_addr"},  32'(bus.status_addr), 32'(exp_addr));
    checkOutput({name, "_data"},  32'(bus.status_data), 32'(exp_data));
    checkOutput({name, "_pcm_l"}, 32'(bus.pcm_l),       32'(exp_pcm_l));
    checkOutput({name, "_pcm_r"}, 32'(bus.pcm_r),       32'(exp_pcm_r));
    checkOutput({name, "_fv_n"},  32'(fv_cnt),          32'(exp_fv));
    checkOutput({name, "_sv_n"},  32'(sv_cnt),          32'(exp_sv));
    checkOutput({name, "_err_n"}, 32'(err_cnt),         32'(exp_err));
  endtask

  initial begin
    int first;
    int gap;
    logic [255:0] fr;

    bus.AUDIO_SYNC     = 1'b0;
    bus.AUDIO_SDATA_IN = 1'b0;
    exp_fv  = 0;
    exp_sv  = 0;
    exp_err = 0;
    modelReset();

    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkAll("reset");

    // Long stretch of noise without any frame sync.
    driveIdle(1000);
    checkAll("nosync");

    // Directed frame with status read-back, including exact commit latency.
    newFrame(16'hF800);
    slot_v[1] = 20'h26000;
    slot_v[2] = 20'h000F0;
    slot_v[3] = 20'h12345;
    slot_v[4] = 20'hABCDE;
    applyStimulus(buildFrame(), 16, 256);
    driveIdle(2);
    checkOutput("lat_early_fv", 32'(bus.frame_valid), 32'd0);
    driveIdle(1);
    checkOutput("lat_fv", 32'(bus.frame_valid), 32'd1);
    checkOutput("lat_sv", 32'(bus.status_valid), 32'd1);
    checkOutput("dir_addr",  32'(bus.status_addr), 32'h26);
    checkOutput("dir_data",  32'(bus.status_data), 32'h000F);
    checkOutput("dir_pcm_l", 32'(bus.pcm_l), 32'h1234);
    checkOutput("dir_pcm_r", 32'(bus.pcm_r), 32'hABCD);
    modelCommit();
    driveIdle(3);
    checkAll("directed");

    // Back-to-back frames without status flags.
    first = fv_cyc.size();
    for (int k = 0; k < 3; k++) begin
      newFrame(16'h9800);
      applyStimulus(buildFrame(), 16, 256);
      modelCommit();
    end
    driveIdle(4);
    checkAll("b2b");
    for (int k = 1; k < 3; k++) begin
      gap = (fv_cyc.size() > first + k) ? (fv_cyc[first+k] - fv_cyc[first+k-1]) : -1;
      checkOutput("b2b_gap", 32'(gap), 32'd256);
    end

    // Sync held one bit too long.
    newFrame(16'hE000 | 16'($urandom));
    applyStimulus(buildFrame(), 17, 256);
    exp_err++;
    driveIdle(4);
    checkAll("sync17");

    // Sync dropped after only 8 bits.
    newFrame(16'hE000 | 16'($urandom));
    applyStimulus(buildFrame(), 8, 256);
    exp_err++;
    driveIdle(4);
    checkAll("sync8");

    // New frame begins at bit 100 of the previous one.
    newFrame(16'($urandom));
    fr = buildFrame();
    applyStimulus(fr, 16, 100);
    newFrame(16'hE000 | 16'($urandom));
    applyStimulus(buildFrame(), 16, 256);
    exp_err++;
    modelCommit();
    driveIdle(4);
    checkAll("restart");

    // One-cycle reset at bit 140, then a clean frame.
    newFrame(16'($urandom));
    applyStimulus(buildFrame(), 16, 140);
    @(negedge clock);
    reset              = 1'b1;
    bus.AUDIO_SYNC     = 1'b0;
    bus.AUDIO_SDATA_IN = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    checkAll("midreset");
    newFrame(16'($urandom));
    applyStimulus(buildFrame(), 16, 256);
    modelCommit();
    driveIdle(4);
    checkAll("postreset");

    // Random frames with random tags and gaps.
    for (int k = 0; k < 4; k++) begin
      newFrame(16'($urandom));
      applyStimulus(buildFrame(), 16, 256);
      modelCommit();
      driveIdle(int'($urandom_range(4, 8)));
      checkAll("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
